mic_array_capture: RTL and testbench



---
 rtl/mic_array_capture.sv | 83 ++++++++
 tb/tb_mic_array_capture.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mic_array_capture.sv
// mic_array_capture: I2S mic array capture with per-channel delay history and activity flags.
module mic_array_capture #(
  parameter int          NUM_LINES   = 4,
  parameter int          CLK_DIV     = 4,
  parameter int          DELAY_DEPTH = 3,
  parameter int          WARMUP      = 4,
  parameter int unsigned GAP_THRESH  = 100000,
  parameter bit          ACT_ABS     = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_dsp,
  output logic                      mic_clk,
  output logic                      mic_ws,
  input  logic [NUM_LINES-1:0]      mic_so,
  output logic [2*NUM_LINES*24-1:0] mic_data,
  output logic                      frame_valid,
  output logic                      start,
  output logic [2*NUM_LINES-1:0]    active
);
  localparam int NCH = 2*NUM_LINES;
  localparam int DW = $clog2(CLK_DIV);
  localparam logic signed [25:0] GAP = 26'(GAP_THRESH);
  logic [DW-1:0] r_div;
  logic [4:0]    r_bit;
  logic          r_commit;
  logic [9:0]    r_frames;
  logic [23:0]   r_sh [NUM_LINES];
  logic [23:0]   r_hist [NCH][DELAY_DEPTH];
  logic          w_tick, w_rise, w_fall, w_take;
  assign w_tick = r_div == DW'(CLK_DIV-1);
  assign w_rise = w_tick && !mic_clk;
  assign w_fall = w_tick && mic_clk;
  assign w_take = w_rise && r_bit >= 5'd1 && r_bit <= 5'd24;
  function automatic logic act(input logic [23:0] n, input logic [23:0] t);
    logic signed [25:0] d;
    d = $signed({{2{n[23]}}, n}) - $signed({{2{t[23]}}, t});
    return ACT_ABS ? (d > GAP || -d > GAP) : d > GAP;
  endfunction
  always_ff @(posedge clk) begin
    if (rst_dsp) begin
      r_div    <= '0;
      mic_clk  <= 1'b0;
      mic_ws   <= 1'b0;
      r_bit    <= '0;
      r_commit <= 1'b0;
      for (int k = 0; k < NUM_LINES; k++) r_sh[k] <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) mic_clk <= !mic_clk;
      if (w_fall) r_bit <= r_bit + 1'b1;
      if (w_fall && r_bit == 5'd31) mic_ws <= !mic_ws;
      r_commit <= w_rise && r_bit == 5'd24;
      if (w_take)
        for (int k = 0; k < NUM_LINES; k++) r_sh[k] <= {r_sh[k][22:0], mic_so[k]};
    end
  end
  // Even channels carry the right word (ws=1), odd channels the left word (ws=0).
  always_ff @(posedge clk) begin
    if (rst_dsp) begin
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < DELAY_DEPTH; i++) r_hist[c][i] <= '0;
      active      <= '0;
      frame_valid <= 1'b0;
      start       <= 1'b0;
      r_frames    <= '0;
    end else begin
      frame_valid <= r_commit && mic_ws;
      if (r_commit) begin
        for (int c = 0; c < NCH; c++)
          if (c[0] != mic_ws) begin
            r_hist[c][0] <= r_sh[c/2];
            for (int i = 1; i < DELAY_DEPTH; i++) r_hist[c][i] <= r_hist[c][i-1];
            active[c] <= act(r_sh[c/2], r_hist[c][DELAY_DEPTH-1]);
          end
        if (mic_ws && r_frames != 10'(WARMUP)) r_frames <= r_frames + 1'b1;
        if (mic_ws && r_frames == 10'(WARMUP-1)) start <= 1'b1;
      end
    end
  end
  for (genvar c = 0; c < NCH; c++) begin : g_out
    assign mic_data[24*c +: 24] = r_hist[c][DELAY_DEPTH-1];
  end
endmodule

// File: tb/tb_mic_array_capture.sv
// tb_mic_array_capture: two instances (ACT_ABS 0/1) driven by an I2S mic model and checked against frame-level arithmetic.
module tb_mic_array_capture;
  localparam int NL = 4, NCH = 8, D = 2, DD = 3, WU = 4, G = 100000, MAXF = 64;
  logic clk = 1'b0, rst_dsp = 1'b1;
  logic [NL-1:0] mic_so = '0;
  logic clk_a, ws_a, fv_a, st_a, clk_b, ws_b, fv_b, st_b;
  logic [NCH*24-1:0] data_a, data_b;
  logic [NCH-1:0] act_a, act_b;
  mic_array_capture #(.NUM_LINES(NL), .CLK_DIV(D), .DELAY_DEPTH(DD), .WARMUP(WU),
                      .GAP_THRESH(G), .ACT_ABS(1'b0)) dut_a (
    .clk(clk), .rst_dsp(rst_dsp), .mic_clk(clk_a), .mic_ws(ws_a), .mic_so(mic_so),
    .mic_data(data_a), .frame_valid(fv_a), .start(st_a), .active(act_a));
  mic_array_capture #(.NUM_LINES(NL), .CLK_DIV(D), .DELAY_DEPTH(DD), .WARMUP(WU),
                      .GAP_THRESH(G), .ACT_ABS(1'b1)) dut_b (
    .clk(clk), .rst_dsp(rst_dsp), .mic_clk(clk_b), .mic_ws(ws_b), .mic_so(mic_so),
    .mic_data(data_b), .frame_valid(fv_b), .start(st_b), .active(act_b));
  always #5 clk = ~clk;
  typedef struct {
    logic [23:0] tap;
    logic [23:0] nw;
    logic        a0;
    logic        a1;
  } vec_t;
  vec_t vt [8];
  int t, pass, total, last_l, last_r, rights;
  logic [23:0] wl [MAXF][NL];
  logic [23:0] wr [MAXF][NL];
  logic [NCH-1:0] e_act0, e_act1;
  logic e_fv;
  task automatic chk(input string nm, input logic [NCH*24-1:0] a, input logic [NCH*24-1:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s t=%0d got %h want %h", nm, t, a, e);
  endtask
  function automatic int tc(input int h);
    return (64*h + 49)*D + 1;
  endfunction
  function automatic logic act_ref(input logic [23:0] n, input logic [23:0] tp, input bit ab);
    int d = int'($signed(n)) - int'($signed(tp));
    return ab ? ((d < 0 ? -d : d) > G) : (d > G);
  endfunction
  function automatic logic [NCH*24-1:0] exp_data();
    logic [NCH*24-1:0] v = '0;
    for (int k = 0; k < NL; k++) begin
      if (last_r >= DD-1) v[48*k +: 24] = wr[last_r-DD+1][k];
      if (last_l >= DD-1) v[48*k+24 +: 24] = wl[last_l-DD+1][k];
    end
    return v;
  endfunction
  // Mic model: bit b of half h goes out after fall b; bits 1..24 are the word MSB first, the rest junk.
  task automatic drive();
    int f = t / (2*D);
    int b = f % 32;
    int h = f / 32;
    logic [NL-1:0] v = NL'($urandom);
    logic [23:0] w;
    if (b >= 1 && b <= 24 && h/2 < MAXF)
      for (int k = 0; k < NL; k++) begin
        w = (h % 2 == 1) ? wr[h/2][k] : wl[h/2][k];
        v[k] = w[24-b];
      end
    mic_so = v;
  endtask
  task automatic cycle();
    int h, fr;
    logic [23:0] tp;
    logic ec, ews, est;
    logic [NCH*24-1:0] ed;
    @(posedge clk); #1;
    t++;
    if (t % (2*D) == 0) drive();
    e_fv = 1'b0;
    if (t-1 >= 49*D && (t-1-49*D) % (64*D) == 0) begin
      h = (t-1-49*D) / (64*D);
      fr = h / 2;
      for (int k = 0; k < NL; k++)
        if (h % 2 == 1) begin
          tp = fr >= DD ? wr[fr-DD][k] : 24'd0;
          e_act0[2*k] = act_ref(wr[fr][k], tp, 1'b0);
          e_act1[2*k] = act_ref(wr[fr][k], tp, 1'b1);
        end else begin
          tp = fr >= DD ? wl[fr-DD][k] : 24'd0;
          e_act0[2*k+1] = act_ref(wl[fr][k], tp, 1'b0);
          e_act1[2*k+1] = act_ref(wl[fr][k], tp, 1'b1);
        end
      if (h % 2 == 1) begin
        last_r = fr;
        rights++;
        e_fv = 1'b1;
      end else last_l = fr;
    end
    ec  = (t / D) % 2 == 1;
    ews = (t / (64*D)) % 2 == 1;
    est = rights >= WU;
    ed  = exp_data();
    chk("ctl", {clk_a, ws_a, fv_a, st_a, act_a, clk_b, ws_b, fv_b, st_b, act_b},
               {ec, ews, e_fv, est, e_act0, ec, ews, e_fv, est, e_act1});
    chk("data_a", data_a, ed);
    chk("data_b", data_b, ed);
  endtask
  task automatic run_to(input int tgt);
    while (t < tgt && total - pass < 40) cycle();
  endtask
  task automatic do_reset();
    rst_dsp = 1'b1;
    @(posedge clk); #1;
    chk("rst_a", {clk_a, ws_a, fv_a, st_a, act_a, data_a}, '0);
    chk("rst_b", {clk_b, ws_b, fv_b, st_b, act_b, data_b}, '0);
    @(posedge clk); #1;
    rst_dsp = 1'b0;
    t = 0;
    last_l = -1;
    last_r = -1;
    rights = 0;
    e_act0 = '0;
    e_act1 = '0;
    drive();
  endtask
  function automatic logic [23:0] rnd_word(input logic [23:0] ref_w);
    int s = int'($urandom_range(0, 9));
    return s == 0 ? 24'h7FFFFF : s == 1 ? 24'h800000 : s == 2 ? 24'h000000 :
           s == 3 ? 24'hFFFFFF : s == 4 ? ref_w + 24'(G) + 24'($urandom_range(0, 2)) - 24'd1 :
           s == 5 ? ref_w - 24'(G) + 24'($urandom_range(0, 2)) - 24'd1 : 24'($urandom);
  endfunction
  initial begin
    pass = 0;
    total = 0;
    vt[0] = '{24'h000000, 24'h0186A1, 1'b1, 1'b1};
    vt[1] = '{24'h000000, 24'h0186A0, 1'b0, 1'b0};
    vt[2] = '{24'h000000, 24'hFE795F, 1'b0, 1'b1};
    vt[3] = '{24'h7FFFFF, 24'h800000, 1'b0, 1'b1};
    vt[4] = '{24'h800000, 24'h7FFFFF, 1'b1, 1'b1};
    vt[5] = '{24'h000005, 24'h0186A5, 1'b0, 1'b0};
    vt[6] = '{24'h000005, 24'h0186A6, 1'b1, 1'b1};
    vt[7] = '{24'h030D40, 24'h01869F, 1'b0, 1'b1};
    for (int f = 0; f < MAXF; f++)
      for (int k = 0; k < NL; k++) begin
        wl[f][k] = f < 6 ? 24'h100000 + 24'(k) : 24'h200000 + 24'(k);
        wr[f][k] = f < 6 ? 24'hF00000 - 24'(k) : 24'hE00000 - 24'(k);
      end
    do_reset();
    chk("release", {clk_a, ws_a, clk_b, ws_b}, '0);
    run_to(1); chk("mclk_t1", clk_a, 0);
    run_to(2); chk("mclk_t2", clk_a, 1);
    run_to(3); chk("mclk_t3", clk_a, 1);
    run_to(4); chk("mclk_t4", clk_a, 0);
    run_to(127); chk("ws_t127", ws_a, 0);
    run_to(128); chk("ws_t128", ws_a, 1);
    run_to(tc(2));
    for (int k = 0; k < NL; k++) chk("l_pre", data_a[48*k+24 +: 24], 0);
    run_to(tc(4));
    for (int k = 0; k < NL; k++) begin
      chk("l_3rd", data_a[48*k+24 +: 24], 24'h100000 + 24'(k));
      chk("r_pre", data_a[48*k +: 24], 0);
    end
    run_to(tc(5));
    for (int k = 0; k < NL; k++) chk("r_3rd", data_a[48*k +: 24], 24'hF00000 - 24'(k));
    chk("fv_3", fv_a, 1);
    chk("st_3", st_a, 0);
    run_to(tc(5) + 1); chk("fv_off", fv_a, 0);
    run_to(tc(7) - 1); chk("st_pre", st_a, 0);
    run_to(tc(7)); chk("fv_st_4", {fv_a, st_a, fv_b, st_b}, 4'hF);
    run_to(tc(14)); chk("old_pat", data_a[24 +: 24], 24'h100000);
    run_to(tc(16)); chk("new_pat", data_a[24 +: 24], 24'h200000);
    run_to(4*812);
    chk("mid_right", {ws_a, st_a}, 2'b11);
    do_reset();
    for (int f = 0; f < MAXF; f++)
      for (int k = 0; k < NL; k++) begin
        wl[f][k] = 24'($urandom);
        wr[f][k] = 24'($urandom);
      end
    for (int v = 0; v < 8; v++) begin
      wl[4*v][0] = vt[v].tap;
      wl[4*v+3][0] = vt[v].nw;
    end
    run_to(tc(5)); chk("st_fresh", st_a, 0);
    for (int v = 0; v < 8; v++) begin
      run_to(tc(2*(4*v+3)));
      chk($sformatf("vec%0d_abs0", v), act_a[1], vt[v].a0);
      chk($sformatf("vec%0d_abs1", v), act_b[1], vt[v].a1);
    end
    do_reset();
    for (int f = 0; f < MAXF; f++)
      for (int k = 0; k < NL; k++) begin
        wl[f][k] = rnd_word(f >= DD ? wl[f-DD][k] : 24'd0);
        wr[f][k] = rnd_word(f >= DD ? wr[f-DD][k] : 24'd0);
      end
    run_to(tc(2*47+1) + 3);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
